// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback sequencer.
package wb_pkg;

  localparam int unsigned DEF_FIFO_DEPTH = 2;
  localparam int unsigned ADDR_W         = 4;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned FLAGS_W        = 9;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FIRST  = 2'd1;
  localparam logic [1:0] ST_SECOND = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr_d;
    logic [ADDR_W-1:0]  addr_x;
    logic [DATA_W-1:0]  d;
    logic               word;
    logic               hi;
    logic               xchg;
    logic               wrfl;
    logic [FLAGS_W-1:0] flags;
    logic               ip0;
  } wb_entry_t;

  localparam int unsigned ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO with count-based full/empty and a whole-queue flush.
module wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // A flush wins over both push and pop on the same edge.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_seq.sv
// Writeback sequencer: buffers exec results and drives the regfile write port,
// splitting XCHG results into two consecutive writes.
module wb_seq
  import wb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr_d,
  input  logic [DATA_W-1:0]  req_d,
  input  logic               req_word,
  input  logic               req_hi,
  input  logic               req_xchg,
  input  logic [ADDR_W-1:0]  req_addr_x,
  input  logic               req_wrfl,
  input  logic [FLAGS_W-1:0] req_flags,
  input  logic               req_ip0,
  input  logic               flush,
  output logic               wr,
  output logic               wrfl,
  output logic               wrhi,
  output logic               wr_ip0,
  output logic [ADDR_W-1:0]  addr_d,
  output logic [DATA_W-1:0]  d,
  output logic               word_op,
  output logic [FLAGS_W-1:0] iflags,
  output logic               busy
);

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  wb_entry_t          cur;
  wb_entry_t          cur_nxt;
  wb_entry_t          head;
  wb_entry_t          in_entry;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               can_pop;
  logic               wr_nxt;
  logic               wrfl_nxt;
  logic               wrhi_nxt;
  logic               wr_ip0_nxt;
  logic [ADDR_W-1:0]  addr_d_nxt;
  logic [DATA_W-1:0]  d_nxt;
  logic               word_op_nxt;
  logic [FLAGS_W-1:0] iflags_nxt;

  assign in_entry = '{addr_d: req_addr_d, addr_x: req_addr_x, d: req_d,
                      word: req_word, hi: req_hi, xchg: req_xchg,
                      wrfl: req_wrfl, flags: req_flags, ip0: req_ip0};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid & req_ready),
    .pop   (pop),
    .flush (flush),
    .din   (in_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign req_ready = ~fifo_full;
  assign busy      = ~fifo_empty | (state != ST_IDLE);
  // Flushed entries are never issued, including the head.
  assign can_pop   = ~fifo_empty & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cur   <= '0;
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
    end
  end

  // Next-state plus next write-port values, derived from the upcoming state.
  always_comb begin
    state_nxt   = state;
    cur_nxt     = cur;
    pop         = 1'b0;
    wr_nxt      = 1'b0;
    wrfl_nxt    = 1'b0;
    wrhi_nxt    = 1'b0;
    wr_ip0_nxt  = 1'b0;
    addr_d_nxt  = '0;
    d_nxt       = '0;
    word_op_nxt = 1'b0;
    iflags_nxt  = '0;

    case (state)
      ST_IDLE: begin
        if (can_pop) begin
          pop       = 1'b1;
          cur_nxt   = head;
          state_nxt = ST_FIRST;
        end
      end
      ST_FIRST: begin
        if (cur.xchg) begin
          state_nxt = ST_SECOND;
        end else if (can_pop) begin
          pop       = 1'b1;
          cur_nxt   = head;
          state_nxt = ST_FIRST;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SECOND: begin
        if (can_pop) begin
          pop       = 1'b1;
          cur_nxt   = head;
          state_nxt = ST_FIRST;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    case (state_nxt)
      ST_FIRST: begin
        wr_nxt      = 1'b1;
        addr_d_nxt  = cur_nxt.addr_d;
        d_nxt       = cur_nxt.d;
        word_op_nxt = cur_nxt.word;
        wrhi_nxt    = cur_nxt.hi & ~cur_nxt.xchg;
        wrfl_nxt    = cur_nxt.wrfl;
        iflags_nxt  = cur_nxt.flags;
        wr_ip0_nxt  = cur_nxt.ip0;
      end
      ST_SECOND: begin
        wr_nxt      = 1'b1;
        addr_d_nxt  = cur_nxt.addr_x;
        d_nxt       = {16'h0, cur_nxt.d[31:16]};
        word_op_nxt = cur_nxt.word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr      <= 1'b0;
      wrfl    <= 1'b0;
      wrhi    <= 1'b0;
      wr_ip0  <= 1'b0;
      addr_d  <= '0;
      d       <= '0;
      word_op <= 1'b0;
      iflags  <= '0;
    end else begin
      wr      <= wr_nxt;
      wrfl    <= wrfl_nxt;
      wrhi    <= wrhi_nxt;
      wr_ip0  <= wr_ip0_nxt;
      addr_d  <= addr_d_nxt;
      d       <= d_nxt;
      word_op <= word_op_nxt;
      iflags  <= iflags_nxt;
    end
  end

endmodule

// File: tb/tb_wb_seq.sv
// Scoreboard bench for wb_seq: stimulus queues expected regfile writes,
// a negedge monitor pops and compares them whenever wr is asserted.
module tb_wb_seq;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_addr_d = '0;
  logic [31:0] req_d = '0;
  logic        req_word = 1'b0;
  logic        req_hi = 1'b0;
  logic        req_xchg = 1'b0;
  logic [3:0]  req_addr_x = '0;
  logic        req_wrfl = 1'b0;
  logic [8:0]  req_flags = '0;
  logic        req_ip0 = 1'b0;
  logic        flush = 1'b0;
  logic        wr, wrfl, wrhi, wr_ip0, word_op, busy;
  logic [3:0]  addr_d;
  logic [31:0] d;
  logic [8:0]  iflags;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] d;
    logic        word;
    logic        hi;
    logic        fl;
    logic [8:0]  flags;
    logic        ip0;
  } exp_t;

  exp_t exp_q[$];
  int   wr_cyc_q[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  wb_seq dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr_d(req_addr_d), .req_d(req_d), .req_word(req_word),
    .req_hi(req_hi), .req_xchg(req_xchg), .req_addr_x(req_addr_x),
    .req_wrfl(req_wrfl), .req_flags(req_flags), .req_ip0(req_ip0),
    .flush(flush), .wr(wr), .wrfl(wrfl), .wrhi(wrhi), .wr_ip0(wr_ip0),
    .addr_d(addr_d), .d(d), .word_op(word_op), .iflags(iflags), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic wb_entry_t mk(input logic [3:0] ad, input logic [3:0] ax,
                                   input logic [31:0] dv, input logic wd,
                                   input logic hi, input logic xc, input logic fl,
                                   input logic [8:0] fg, input logic ip);
    wb_entry_t e;
    e = '{addr_d: ad, addr_x: ax, d: dv, word: wd, hi: hi, xchg: xc,
          wrfl: fl, flags: fg, ip0: ip};
    return e;
  endfunction

  // nwr: how many of this entry's regfile writes are expected to appear.
  task automatic expect_writes(input wb_entry_t e, input int nwr);
    if (nwr >= 1) begin
      if (e.xchg) exp_q.push_back('{addr: e.addr_d, d: e.d, word: e.word, hi: 1'b0,
                                    fl: e.wrfl, flags: e.flags, ip0: e.ip0});
      else        exp_q.push_back('{addr: e.addr_d, d: e.d, word: e.word, hi: e.hi,
                                    fl: e.wrfl, flags: e.flags, ip0: e.ip0});
    end
    if (nwr >= 2)
      exp_q.push_back('{addr: e.addr_x, d: {16'h0, e.d[31:16]}, word: e.word,
                        hi: 1'b0, fl: 1'b0, flags: 9'h0, ip0: 1'b0});
  endtask

  task automatic drive(input wb_entry_t e);
    req_addr_d = e.addr_d; req_addr_x = e.addr_x; req_d = e.d;
    req_word = e.word; req_hi = e.hi; req_xchg = e.xchg;
    req_wrfl = e.wrfl; req_flags = e.flags; req_ip0 = e.ip0;
    req_valid = 1'b1;
  endtask

  // Offer one entry; returns just after the accepting posedge.
  task automatic send(input wb_entry_t e, input int nwr);
    int n = 0;
    @(negedge clk);
    drive(e);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("ready_timeout", 64'(n), 64'd0);
      req_valid = 1'b0;
    end else begin
      expect_writes(e, nwr);
      @(posedge clk);
    end
  endtask

  // Monitor: every wr pulse must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t act;
    exp_t e;
    if (!rst) begin
      act = '{addr: addr_d, d: d, word: word_op, hi: wrhi, fl: wrfl,
              flags: iflags, ip0: wr_ip0};
      if (wr) begin
        wr_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected_wr", 64'(exp_q.size()), 64'd1);
        else begin
          e = exp_q.pop_front();
          chk("wr_payload", 64'(act), 64'(e));
        end
      end else if (act != '0) begin
        chk("idle_outputs", 64'(act), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_entry_t x;
    // Reset state while rst is high, before any clock edge
    #1;
    chk("rst_wr", 64'(wr), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single word write, latency 2 edges, one-cycle pulse
    send(mk(4'd3, 4'd0, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 1'b0, 9'h0, 1'b0), 1);
    @(negedge clk); req_valid = 1'b0;
    chk("lat_edge_k", 64'(wr), 64'd0);
    chk("busy_queued", 64'(busy), 64'd1);
    @(negedge clk);
    chk("lat_edge_k1", 64'(wr), 64'd1);
    @(negedge clk);
    chk("single_pulse", 64'(wr), 64'd0);

    // MUL-style result with DX write
    send(mk(4'd0, 4'd0, 32'hABCD_0042, 1'b1, 1'b1, 1'b0, 1'b0, 9'h0, 1'b0), 1);
    // Byte write with flags and IP copy
    send(mk(4'd14, 4'd0, 32'h0000_00FE, 1'b0, 1'b0, 1'b0, 1'b1, 9'h1A5, 1'b1), 1);
    @(negedge clk); req_valid = 1'b0;
    repeat (4) @(negedge clk);

    // XCHG with hi set: hi suppressed, two consecutive writes
    wr_cyc_q.delete();
    send(mk(4'd0, 4'd3, 32'h5555_AAAA, 1'b1, 1'b1, 1'b1, 1'b0, 9'h0, 1'b0), 2);
    @(negedge clk); req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("xchg_nwrites", 64'(wr_cyc_q.size()), 64'd2);
    if (wr_cyc_q.size() == 2) chk("xchg_consecutive", 64'(wr_cyc_q[1] - wr_cyc_q[0]), 64'd1);

    // Back-to-back plain entries: no gaps, no drops
    wr_cyc_q.delete();
    send(mk(4'd1, 4'd0, 32'h0000_1111, 1'b1, 1'b0, 1'b0, 1'b0, 9'h0, 1'b0), 1);
    send(mk(4'd2, 4'd0, 32'h0000_2222, 1'b1, 1'b0, 1'b0, 1'b0, 9'h0, 1'b0), 1);
    send(mk(4'd5, 4'd0, 32'h0000_3333, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 1'b0), 1);
    @(negedge clk); req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("b2b_nwrites", 64'(wr_cyc_q.size()), 64'd3);
    if (wr_cyc_q.size() == 3) begin
      chk("b2b_gap0", 64'(wr_cyc_q[1] - wr_cyc_q[0]), 64'd1);
      chk("b2b_gap1", 64'(wr_cyc_q[2] - wr_cyc_q[1]), 64'd1);
    end

    // Fill to depth behind an XCHG: ready drops, then returns after a pop
    send(mk(4'd6, 4'd7, 32'h1357_2468, 1'b1, 1'b0, 1'b1, 1'b0, 9'h0, 1'b0), 2);
    send(mk(4'd8, 4'd0, 32'h0000_8888, 1'b1, 1'b0, 1'b0, 1'b0, 9'h0, 1'b0), 1);
    send(mk(4'd9, 4'd0, 32'h0000_9999, 1'b1, 1'b0, 1'b0, 1'b1, 9'h0FF, 1'b0), 1);
    @(negedge clk); req_valid = 1'b0;
    chk("ready_full", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("ready_after_pop", 64'(req_ready), 64'd1);
    repeat (4) @(negedge clk);
    chk("busy_drained", 64'(busy), 64'd0);

    // Flush during FIRST of an XCHG: SECOND still issued, queued entry dropped,
    // and a push coincident with the flush is discarded
    send(mk(4'd2, 4'd4, 32'hBEEF_CAFE, 1'b1, 1'b0, 1'b1, 1'b0, 9'h0, 1'b0), 2);
    send(mk(4'd10, 4'd0, 32'h0000_DEAD, 1'b1, 1'b0, 1'b0, 1'b0, 9'h0, 1'b0), 0);
    @(negedge clk);
    drive(mk(4'd11, 4'd0, 32'h0000_F00D, 1'b1, 1'b0, 1'b0, 1'b0, 9'h0, 1'b0));
    flush = 1'b1;
    chk("flush_in_first", 64'(wr), 64'd1);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    chk("flush_second_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("flush_busy_clear", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);

    // Reset asserted mid-XCHG: SECOND suppressed, outputs clear at once
    x = mk(4'd12, 4'd13, 32'h7777_1111, 1'b1, 1'b0, 1'b1, 1'b0, 9'h0, 1'b0);
    send(x, 1);
    @(negedge clk); req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_wr", 64'(wr), 64'd0);
    chk("midrst_d", 64'(d), 64'd0);
    chk("midrst_ready", 64'(req_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk);

    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
